mrgp_regfile_sequencer: RTL
===========================

# mrgp_regfile_sequencer

Command-driven initiator for the 8 x 16-bit general-purpose register file. It accepts one register operation at a time over a valid/ready command port and turns it into a cycle-exact sequence on the register file's source, destination, data, store and reset lines. The register file's read data comes back into this block. The sequencer sits between the control unit and the register file, and is the only agent driving the register file's write side.

## Interface
Parameters: none. The register count (8), data width (16) and address encoding are fixed.

Ports:
- CLK  in  1  system clock; everything is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command; high only in IDLE.
- CMD_OP  in  2  operation code: 00 LOADI, 01 MOVE, 10 SWAP, 11 CLEAR.
- CMD_A  in  3  register index A (destination for LOADI and MOVE).
- CMD_B  in  3  register index B (source for MOVE).
- CMD_IMM  in  16  immediate value for LOADI.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  16  operation result; held until the next DONE.
- RF_SRC  out  16  register file read select; bits[5:3] = index, all other bits 0.
- RF_DST  out  16  register file write select; bits[5:3] = index, bits[7:6] = 00 enables a write.
- RF_D_IN  out  16  register file write data.
- RF_STO  out  1  register file store strobe.
- RF_RST  out  1  register file zero-write strobe; forces write data to zero.
- RF_D_OUT  in  16  register file read data, combinational from RF_SRC.

## Operation
- Register file contract:
  - Reads are combinational: R[RF_SRC[5:3]] appears on RF_D_OUT in the same cycle.
  - A write commits on a rising CLK edge when (RF_STO | RF_RST) = 1 and RF_DST[7:6] = 00.
  - The register file has no reset of its own.
- Index encoding: register n is encoded as 16'h0000 | (n << 3).
- Idle/parked values: RF_DST = 16'h00C0 whenever no write is intended, which makes the register file write-disabled. RF_SRC = 0, RF_D_IN = 0, RF_STO = 0, RF_RST = 0.
- States and sequences (a command is accepted on an edge where CMD_VALID & CMD_READY):
  - IDLE
  - LOADI: one cycle in WR. RF_DST = enc(A), RF_D_IN = IMM, RF_STO = 1. RESULT = IMM.
  - MOVE:
    - RD1: RF_SRC = enc(B); TMP0 <= RF_D_OUT.
    - WR1: RF_DST = enc(A), RF_D_IN = TMP0, RF_STO = 1.
    - RESULT = TMP0.
  - SWAP:
    - RD1: RF_SRC = enc(A); TMP0 <= RF_D_OUT.
    - RD2: RF_SRC = enc(B); TMP1 <= RF_D_OUT.
    - WR1: RF_DST = enc(A), RF_D_IN = TMP1, RF_STO = 1.
    - WR2: RF_DST = enc(B), RF_D_IN = TMP0, RF_STO = 1.
    - RESULT = original R[A].
  - CLEAR: eight CLR cycles with a 3-bit counter running 0..7. RF_DST = enc(count), RF_RST = 1, RF_STO = 0. RESULT = 0. A and B are ignored.
- After the last busy cycle the FSM returns to IDLE. DONE = 1 for exactly that first IDLE cycle.
- RESULT updates on the same edge that raises DONE.
- CMD_* inputs are sampled only at acceptance. Changes while busy are ignored, and CMD_VALID while busy causes no effect.
- Degenerate operands:
  - SWAP with A == B: the full 4 cycles still run and the net register state is unchanged.
  - MOVE with A == B: rewrites the same value.

## Timing
- Reset values (asynchronous, while RST_N = 0): IDLE state, CMD_READY = 1 after release, DONE = 0, RESULT = 0, TMP0 = TMP1 = 0, CLR count = 0. RF_* outputs take the parked values, so RF_STO = RF_RST = 0 immediately.
- Busy cycles: LOADI 1, MOVE 2, SWAP 4, CLEAR 8. CMD_READY is low for exactly those cycles.
- Throughput: command-to-command minimum is busy cycles + 1. The next command can be accepted on the edge that ends the DONE cycle.
- Visibility: a write committed at edge k is visible on RF_D_OUT from cycle k+1. This guarantees SWAP/MOVE reads after an earlier write return the new data.
- Reset asserted mid-operation:
  - All strobes drop combinationally, so any write not yet committed at a clock edge does not occur.
  - Writes committed before reset remain; there is no rollback.
  - No DONE is produced for the aborted command.
- All RF_* outputs are registered or decoded from state registers only. There is no combinational path from RF_D_OUT to any output.

## Test plan
- Reset, then LOADI A=3 IMM=16'hBEEF. Required: for one cycle RF_DST = 16'h0018, RF_D_IN = 16'hBEEF, RF_STO = 1. Next cycle DONE = 1, RESULT = 16'hBEEF, and the model's R3 = 16'hBEEF.
- MOVE A=5 B=3 after the above. Required: cycle 1 RF_SRC = 16'h0018. Cycle 2 RF_DST = 16'h0028, RF_D_IN = 16'hBEEF, RF_STO = 1. Then DONE with R5 = 16'hBEEF.
- Preload R1 = 16'h1111 and R2 = 16'h2222, then SWAP A=1 B=2. Required: CMD_READY low for 4 cycles, R1 = 16'h2222, R2 = 16'h1111, RESULT = 16'h1111. Repeating with SWAP A=1 B=1 leaves R1 unchanged.
- Load all 8 registers nonzero, then CLEAR. Required: RF_RST = 1 for 8 cycles while RF_DST steps 16'h0000, 0008, ... 0038. RF_STO = 0 throughout. All registers read 0 afterwards and RESULT = 0.
- Hold CMD_VALID high with a stream of LOADIs, and toggle CMD_* while busy. Required: one acceptance every 2 cycles, and only the values present at acceptance take effect.
- Assert RST_N = 0 during the SWAP WR1 cycle, before the edge. Required: RF_STO = 0 and RF_DST = 16'h00C0 immediately, R1 and R2 unchanged, no DONE, and CMD_READY = 1 once RST_N is released.

Source files
------------

// File: rtl/mrgp_regfile_sequencer_if.sv
// rtl/mrgp_regfile_sequencer_if.sv - command port and register file bus of the regfile sequencer
interface mrgp_regfile_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_a;
    logic [2:0]  cmd_b;
    logic [15:0] cmd_imm;
    logic        done;
    logic [15:0] result;
    logic [15:0] rf_src;
    logic [15:0] rf_dst;
    logic [15:0] rf_d_in;
    logic        rf_sto;
    logic        rf_rst;
    logic [15:0] rf_d_out;

    // master: control unit plus register file; slave: the sequencer itself
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_imm, rf_d_out,
        input  cmd_ready, done, result, rf_src, rf_dst, rf_d_in, rf_sto, rf_rst
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_imm, rf_d_out,
        output cmd_ready, done, result, rf_src, rf_dst, rf_d_in, rf_sto, rf_rst
    );
endinterface

// File: rtl/mrgp_regfile_sequencer.sv
// rtl/mrgp_regfile_sequencer.sv - command-driven LOADI/MOVE/SWAP/CLEAR sequencer for an 8x16 register file
module mrgp_regfile_sequencer (
    input  logic                     clk,
    input  logic                     rst_n,
    mrgp_regfile_sequencer_if.slave  bus
);
    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_WR2  = 3'd5;
    localparam logic [2:0] S_CLR  = 3'd6;

    localparam logic [15:0] DST_PARKED = 16'h00C0;

    logic [2:0]  state;
    logic [1:0]  op;
    logic [2:0]  idx_a;
    logic [2:0]  idx_b;
    logic [15:0] imm;
    logic [15:0] tmp0;
    logic [15:0] tmp1;
    logic [2:0]  cnt;
    logic        done_q;
    logic [15:0] result_q;

    function automatic logic [15:0] enc(input logic [2:0] idx);
        return {10'd0, idx, 3'd0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op       <= OP_LOADI;
            idx_a    <= 3'd0;
            idx_b    <= 3'd0;
            imm      <= 16'd0;
            tmp0     <= 16'd0;
            tmp1     <= 16'd0;
            cnt      <= 3'd0;
            done_q   <= 1'b0;
            result_q <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op    <= bus.cmd_op;
                        idx_a <= bus.cmd_a;
                        idx_b <= bus.cmd_b;
                        imm   <= bus.cmd_imm;
                        cnt   <= 3'd0;
                        case (bus.cmd_op)
                            OP_LOADI: state <= S_WR;
                            OP_CLEAR: state <= S_CLR;
                            default:  state <= S_RD1;
                        endcase
                    end
                end
                S_WR: begin
                    state    <= S_IDLE;
                    done_q   <= 1'b1;
                    result_q <= imm;
                end
                S_RD1: begin
                    tmp0  <= bus.rf_d_out;
                    state <= (op == OP_MOVE) ? S_WR1 : S_RD2;
                end
                S_RD2: begin
                    tmp1  <= bus.rf_d_out;
                    state <= S_WR1;
                end
                S_WR1: begin
                    if (op == OP_MOVE) begin
                        state    <= S_IDLE;
                        done_q   <= 1'b1;
                        result_q <= tmp0;
                    end else begin
                        state <= S_WR2;
                    end
                end
                S_WR2: begin
                    state    <= S_IDLE;
                    done_q   <= 1'b1;
                    result_q <= tmp0;
                end
                S_CLR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state    <= S_IDLE;
                        done_q   <= 1'b1;
                        result_q <= 16'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file lines decode from state only, so an async reset parks them at once.
    always_comb begin
        bus.rf_src  = 16'd0;
        bus.rf_dst  = DST_PARKED;
        bus.rf_d_in = 16'd0;
        bus.rf_sto  = 1'b0;
        bus.rf_rst  = 1'b0;
        case (state)
            S_WR: begin
                bus.rf_dst  = enc(idx_a);
                bus.rf_d_in = imm;
                bus.rf_sto  = 1'b1;
            end
            S_RD1: bus.rf_src = enc((op == OP_MOVE) ? idx_b : idx_a);
            S_RD2: bus.rf_src = enc(idx_b);
            S_WR1: begin
                bus.rf_dst  = enc(idx_a);
                bus.rf_d_in = (op == OP_MOVE) ? tmp0 : tmp1;
                bus.rf_sto  = 1'b1;
            end
            S_WR2: begin
                bus.rf_dst  = enc(idx_b);
                bus.rf_d_in = tmp0;
                bus.rf_sto  = 1'b1;
            end
            S_CLR: begin
                bus.rf_dst = enc(cnt);
                bus.rf_rst = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
endmodule
